// File: rtl/regfile_scoreboard.sv
// Integer register file with two read ports, one write-back port,
// write-through bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int            XLEN      = 32,
  parameter int            NREGS     = 32,
  parameter int            ADDR_W    = 5,
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter bit            ZERO_REG  = 1'b1,
  parameter bit            BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              rd_wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic [NREGS-1:0]  busy_vec,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              sb_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  localparam int CW = ADDR_W + 1;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wb_ok, hit1, hit2;

  function automatic logic valid(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NREGS)) && !(ZERO_REG && (a == '0));
  endfunction

  // Out-of-range addresses match no entry and read as zero
  function automatic logic [XLEN-1:0] rd_reg(input logic [ADDR_W-1:0] a);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++)
      if (a == ADDR_W'(i)) r = regs_q[i];
    return r;
  endfunction

  function automatic logic busy_at(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (a == ADDR_W'(i)) b = busy_q[i];
    return b;
  endfunction

  // Next state: register writes, scoreboard set/clear, count, sticky error
  always_comb begin
    wb_ok = rd_wr_en && valid(rd_addr);
    regs_d = regs_q;
    busy_d = busy_q;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (wb_ok && (rd_addr == ADDR_W'(i))) begin
        regs_d[i] = rd_data;
        busy_d[i] = 1'b0;
      end
      if (iss_en && valid(iss_rd) && (iss_rd == ADDR_W'(i)))
        busy_d[i] = 1'b1;
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
    err_d = err_q | (wb_ok && !busy_at(rd_addr));
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (ZERO_REG && i == 0) ? '0 : RESET_VAL;
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Read ports with same-cycle write-back forwarding
  always_comb begin
    hit1 = BYPASS && wb_ok && (rd_addr == rs1_addr);
    hit2 = BYPASS && wb_ok && (rd_addr == rs2_addr);
    rs1_data = '0;
    rs2_data = '0;
    if (valid(rs1_addr)) rs1_data = hit1 ? rd_data : rd_reg(rs1_addr);
    if (valid(rs2_addr)) rs2_data = hit2 ? rd_data : rd_reg(rs2_addr);
    rs1_busy = valid(rs1_addr) && !hit1 && busy_at(rs1_addr);
    rs2_busy = valid(rs2_addr) && !hit2 && busy_at(rs2_addr);
    dbg_data = rd_reg(dbg_addr);
  end

  assign busy_vec = busy_q;
  assign pend_cnt = cnt_q;
  assign sb_err   = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: vector table for read/write/scoreboard
// behaviour plus hand-written reset sequences.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREGS = 16;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, iss_rd, dbg_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, rd_data, dbg_data;
  logic            rs1_busy, rs2_busy, rd_wr_en, iss_en, sb_err;
  logic [NREGS-1:0] busy_vec;
  logic [AW:0]     pend_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(AW),
    .RESET_VAL(32'd3), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_wr_en(rd_wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt), .sb_err(sb_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dbg;
    logic [31:0] e_r1d;
    logic        e_r1b;
    logic [31:0] e_r2d;
    logic        e_r2b;
    logic [31:0] e_dbg;
    logic [15:0] e_busy;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [15:0] busy;
    logic [5:0]  cnt;
    logic        err;
  } post_t;

  localparam int NV = 15;
  vec_t  tbl [NV];
  post_t sbq [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_wr_en = 0; rd_addr = 0; rd_data = 0;
    iss_en = 0; iss_rd = 0;
  endtask

  initial begin
    //        we  wa   wd            ie  ir   r1   r2   dbg  r1d           r1b r2d           r2b dbg           busy      cnt err
    tbl[0]  = '{0, 0,  32'h0,        1,  7,   7,   0,   7,   32'h3,        0, 32'h0,        0, 32'h3,        16'h0080, 1, 0};
    tbl[1]  = '{1, 7,  32'hDEADBEEF, 0,  0,   7,   7,   7,   32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'h3,        16'h0000, 0, 0};
    tbl[2]  = '{1, 0,  32'h1234,     0,  0,   0,   7,   7,   32'h0,        0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 16'h0000, 0, 0};
    tbl[3]  = '{0, 0,  32'h0,        1,  9,   0,   7,   0,   32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        16'h0200, 1, 0};
    tbl[4]  = '{1, 9,  32'hA5A5A5A5, 0,  0,   9,   9,   9,   32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'h3,        16'h0000, 0, 0};
    tbl[5]  = '{0, 0,  32'h0,        1,  3,   7,   9,   9,   32'hDEADBEEF, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 16'h0008, 1, 0};
    tbl[6]  = '{0, 0,  32'h0,        1,  4,   3,   4,   4,   32'h3,        1, 32'h3,        0, 32'h3,        16'h0018, 2, 0};
    tbl[7]  = '{0, 0,  32'h0,        1,  5,   4,   3,   5,   32'h3,        1, 32'h3,        1, 32'h3,        16'h0038, 3, 0};
    tbl[8]  = '{1, 4,  32'h44,       1,  4,   4,   5,   4,   32'h44,       0, 32'h3,        1, 32'h3,        16'h0038, 3, 0};
    tbl[9]  = '{1, 3,  32'h33,       0,  0,   4,   3,   4,   32'h44,       1, 32'h33,       0, 32'h44,       16'h0030, 2, 0};
    tbl[10] = '{1, 12, 32'hC0C0,     0,  0,   12,  3,   12,  32'hC0C0,     0, 32'h33,       0, 32'h3,        16'h0030, 2, 1};
    tbl[11] = '{1, 20, 32'hFFFF,     1,  20,  20,  12,  20,  32'h0,        0, 32'hC0C0,     0, 32'h0,        16'h0030, 2, 1};
    tbl[12] = '{1, 5,  32'h55,       0,  0,   20,  5,   5,   32'h0,        0, 32'h55,       0, 32'h3,        16'h0010, 1, 1};
    tbl[13] = '{0, 0,  32'h0,        1,  0,   0,   4,   0,   32'h0,        0, 32'h44,       1, 32'h0,        16'h0010, 1, 1};
    tbl[14] = '{0, 0,  32'h0,        1,  15,  15,  4,   15,  32'h3,        0, 32'h44,       1, 32'h3,        16'h8010, 2, 1};

    idle();
    rs1_addr = 5; rs2_addr = 0; dbg_addr = 0;
    reset = 1'b1;
    #2;
    chk("rst_rs1_5", rs1_data, 32'h3);
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_cnt", 32'(pend_cnt), 32'h0);
    chk("rst_err", 32'(sb_err), 32'h0);
    rs1_addr = 0;
    #1;
    chk("rst_rs1_0", rs1_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rd_wr_en = tbl[i].we; rd_addr = tbl[i].wa; rd_data = tbl[i].wd;
      iss_en = tbl[i].ie; iss_rd = tbl[i].ir;
      rs1_addr = tbl[i].r1; rs2_addr = tbl[i].r2; dbg_addr = tbl[i].dbg;
      sbq.push_back('{tbl[i].e_busy, tbl[i].e_cnt, tbl[i].e_err});
      #1;
      chk($sformatf("v%0d_rs1_data", i), rs1_data, tbl[i].e_r1d);
      chk($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].e_r1b));
      chk($sformatf("v%0d_rs2_data", i), rs2_data, tbl[i].e_r2d);
      chk($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].e_r2b));
      chk($sformatf("v%0d_dbg", i), dbg_data, tbl[i].e_dbg);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d_queue got empty exp entry", i);
      end else begin
        post_t p;
        p = sbq.pop_front();
        chk($sformatf("v%0d_busy_vec", i), 32'(busy_vec), 32'(p.busy));
        chk($sformatf("v%0d_pend_cnt", i), 32'(pend_cnt), 32'(p.cnt));
        chk($sformatf("v%0d_sb_err", i), 32'(sb_err), 32'(p.err));
      end
    end

    // Written values survive with writes idle; dbg sees them
    @(negedge clk);
    idle();
    rs1_addr = 12; rs2_addr = 9; dbg_addr = 7;
    #1;
    chk("hold_rs1_12", rs1_data, 32'hC0C0);
    chk("hold_rs2_9", rs2_data, 32'hA5A5A5A5);
    chk("hold_dbg_7", dbg_data, 32'hDEADBEEF);
    chk("hold_rs1_busy", 32'(rs1_busy), 32'h0);

    // Reset asserted between edges, overriding a pending write/issue
    @(negedge clk);
    rd_wr_en = 1; rd_addr = 4; rd_data = 32'h99;
    iss_en = 1; iss_rd = 6;
    rs1_addr = 5; rs2_addr = 12; dbg_addr = 4;
    reset = 1'b1;
    #1;
    chk("mid_rst_rs1_5", rs1_data, 32'h3);
    chk("mid_rst_busy", 32'(busy_vec), 32'h0);
    chk("mid_rst_cnt", 32'(pend_cnt), 32'h0);
    chk("mid_rst_err", 32'(sb_err), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_dbg_4", dbg_data, 32'h3);
    chk("mid_rst_rs2_12", rs2_data, 32'h3);
    chk("mid_rst_busy2", 32'(busy_vec), 32'h0);
    chk("mid_rst_err2", 32'(sb_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // After reset, a legal issue/write-back pair leaves sb_err clear
    @(negedge clk);
    iss_en = 1; iss_rd = 2;
    @(negedge clk);
    idle();
    rs1_addr = 2;
    #1;
    chk("post_rst_busy2", 32'(rs1_busy), 32'h1);
    @(negedge clk);
    rd_wr_en = 1; rd_addr = 2; rd_data = 32'h22;
    @(posedge clk);
    #1;
    chk("post_rst_err", 32'(sb_err), 32'h0);
    chk("post_rst_cnt", 32'(pend_cnt), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("post_rst_rs1_2", rs1_data, 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
